// File: rtl/alu_arbiter_if.sv
// Requester and result handshake bundle for alu_arbiter; the master side drives requests and rsp_ready,
// and the slave side is the arbiter itself.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_fun;
  logic [31:0] req0_a;
  logic [31:0] req0_b;

  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_fun;
  logic [31:0] req1_a;
  logic [31:0] req1_b;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero;

  modport master (
    output req0_valid, req0_fun, req0_a, req0_b,
    output req1_valid, req1_fun, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  modport slave (
    input  req0_valid, req0_fun, req0_a, req0_b,
    input  req1_valid, req1_fun, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU feeding a single-entry result register; 1-cycle latency.
// Requesters see ready=0 while a held result is not drained; drain and accept can overlap for 1 op/cycle.
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic         CLK,
  input  logic         RST_N,
  alu_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_id_q, rsp_id_d;
  logic        last_q, last_d;

  logic        accept_ok;
  logic        gnt_sel;
  logic        xfer;
  logic [3:0]  sel_fun;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [31:0] alu_res;

  function automatic logic [31:0] alu_op(input logic [3:0] fun,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    case (fun)
      4'd0:    r = a + b;
      4'd1:    r = a << b[4:0];
      4'd2:    r = {31'd0, $signed(a) < $signed(b)};
      4'd3:    r = {31'd0, a < b};
      4'd4:    r = a ^ b;
      4'd5:    r = a >> b[4:0];
      4'd6:    r = a | b;
      4'd7:    r = a & b;
      4'd8:    r = a - b;
      4'd9:    r = a;
      4'd13:   r = $unsigned($signed(a) >>> b[4:0]);
      default: r = 32'hDEADBEEF;
    endcase
    return r;
  endfunction

  // Grant select: 0 = req0, 1 = req1. On a tie the round-robin favours whoever did not win last.
  always_comb begin
    accept_ok = (state_q == IDLE) || bus.rsp_ready;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_sel = FIXED_PRIO ? 1'b0 : ~last_q;
    end else begin
      gnt_sel = bus.req1_valid;
    end
    xfer    = RST_N && accept_ok && (bus.req0_valid || bus.req1_valid);
    sel_fun = gnt_sel ? bus.req1_fun : bus.req0_fun;
    sel_a   = gnt_sel ? bus.req1_a   : bus.req0_a;
    sel_b   = gnt_sel ? bus.req1_b   : bus.req0_b;
    alu_res = alu_op(sel_fun, sel_a, sel_b);
  end

  always_comb begin
    state_d      = state_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_id_d     = rsp_id_q;
    last_d       = last_q;
    if (xfer) begin
      state_d      = FULL;
      rsp_result_d = alu_res;
      rsp_zero_d   = (alu_res == 32'd0);
      rsp_id_d     = gnt_sel;
      last_d       = gnt_sel;
    end else if ((state_q == FULL) && bus.rsp_ready) begin
      state_d = IDLE;
    end
  end

  // Reset wins over any same-cycle transfer or drain; pointer starts at 1 so req0 takes the first tie.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      rsp_result_q <= 32'd0;
      rsp_zero_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
      last_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_id_q     <= rsp_id_d;
      last_q       <= last_d;
    end
  end

  assign bus.req0_ready = xfer && !gnt_sel;
  assign bus.req1_ready = xfer && gnt_sel;
  assign bus.rsp_valid  = (state_q == FULL);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: round-robin instance with a result scoreboard, plus a fixed-priority instance.
module tb_alu_arbiter;

  logic CLK;
  logic RST_N;

  alu_arbiter_if bus();
  alu_arbiter_if bus_fp();

  alu_arbiter #(.FIXED_PRIO(1'b0)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  alu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (.CLK(CLK), .RST_N(RST_N), .bus(bus_fp));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [4:0]  sh;
    logic [31:0] r;
    sh = b[4:0];
    r  = 32'hDEADBEEF;
    if (f == 4'd0)  r = a + b;
    if (f == 4'd1)  r = a << sh;
    if (f == 4'd2)  r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
    if (f == 4'd3)  r = {31'd0, a < b};
    if (f == 4'd4)  r = a ^ b;
    if (f == 4'd5)  r = a >> sh;
    if (f == 4'd6)  r = a | b;
    if (f == 4'd7)  r = a & b;
    if (f == 4'd8)  r = a + ~b + 32'd1;
    if (f == 4'd9)  r = a;
    if (f == 4'd13) r = (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: check readies at the falling edge, retire a drained result, record newly accepted ops.
  task automatic cycle(input logic e0, input logic e1);
    exp_t e;
    @(negedge CLK);
    chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, e0});
    chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, e1});
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow: got unexpected result %h expected none", bus.rsp_result);
      end else begin
        e = sb.pop_front();
        chk("sb_id",     {31'd0, bus.rsp_id},   {31'd0, e.id});
        chk("sb_result", bus.rsp_result,        e.res);
        chk("sb_zero",   {31'd0, bus.rsp_zero}, {31'd0, e.zero});
      end
    end
    if (e0) begin
      e.id   = 1'b0;
      e.res  = ref_alu(bus.req0_fun, bus.req0_a, bus.req0_b);
      e.zero = (e.res == 32'd0);
      sb.push_back(e);
    end
    if (e1) begin
      e.id   = 1'b1;
      e.res  = ref_alu(bus.req1_fun, bus.req1_a, bus.req1_b);
      e.zero = (e.res == 32'd0);
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0;
    {bus.req0_valid, bus.req1_valid, bus.rsp_ready} = '0;
    {bus.req0_fun, bus.req0_a, bus.req0_b} = '0;
    {bus.req1_fun, bus.req1_a, bus.req1_b} = '0;
    {bus_fp.req0_valid, bus_fp.req1_valid, bus_fp.rsp_ready} = '0;
    {bus_fp.req0_fun, bus_fp.req0_a, bus_fp.req0_b} = '0;
    {bus_fp.req1_fun, bus_fp.req1_a, bus_fp.req1_b} = '0;
    repeat (2) @(posedge CLK);
    #1;

    // Reset state; requests are refused while reset is held.
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    cycle(1'b0, 1'b0);
    chk("rst_valid",  {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_result", bus.rsp_result,         32'd0);
    chk("rst_zero",   {31'd0, bus.rsp_zero},  32'd0);
    chk("rst_id",     {31'd0, bus.rsp_id},    32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    RST_N = 1'b1;

    // Single op: 5 + 7.
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_fun = 4'd0; bus.req0_a = 32'd5; bus.req0_b = 32'd7;
    cycle(1'b1, 1'b0);
    bus.req0_valid = 1'b0;
    chk("single_valid",  {31'd0, bus.rsp_valid}, 32'd1);
    chk("single_result", bus.rsp_result,         32'd12);
    chk("single_id",     {31'd0, bus.rsp_id},    32'd0);
    chk("single_zero",   {31'd0, bus.rsp_zero},  32'd0);
    cycle(1'b0, 1'b0);
    chk("drain_valid", {31'd0, bus.rsp_valid}, 32'd0);

    // Every function code back-to-back from req0.
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.req0_fun = i[3:0];
      bus.req0_a   = $urandom;
      bus.req0_b   = $urandom;
      if (i == 1) bus.req0_a = 32'h8000_0001;
      cycle(1'b1, 1'b0);
    end
    bus.req0_valid = 1'b0;

    // A lone req1 op leaves req1 as last winner, so the next tie starts with req0.
    bus.req1_valid = 1'b1;
    bus.req1_fun = 4'd1; bus.req1_a = 32'h0000_00F1; bus.req1_b = 32'd36;
    cycle(1'b0, 1'b1);
    bus.req1_valid = 1'b0;
    cycle(1'b0, 1'b0);

    // Contention under round-robin.
    bus.req0_valid = 1'b1; bus.req0_fun = 4'd8;  bus.req0_a = 32'd3;          bus.req0_b = 32'd3;
    bus.req1_valid = 1'b1; bus.req1_fun = 4'd13; bus.req1_a = 32'h8000_0000; bus.req1_b = 32'd4;
    cycle(1'b1, 1'b0);
    chk("rr_zero_result", bus.rsp_result,        32'd0);
    chk("rr_zero_flag",   {31'd0, bus.rsp_zero}, 32'd1);
    cycle(1'b0, 1'b1);
    chk("rr_sra_result", bus.rsp_result, 32'hF800_0000);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    cycle(1'b0, 1'b0);

    // Unused function code.
    bus.req0_valid = 1'b1; bus.req0_fun = 4'd11; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
    cycle(1'b1, 1'b0);
    bus.req0_valid = 1'b0;
    chk("illegal_result", bus.rsp_result,        32'hDEAD_BEEF);
    chk("illegal_zero",   {31'd0, bus.rsp_zero}, 32'd0);
    cycle(1'b0, 1'b0);

    // Backpressure: outputs frozen and req1 refused until the consumer drains.
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_fun = 4'd7; bus.req0_a = 32'h0000_F0F0; bus.req0_b = 32'h0000_FF00;
    cycle(1'b1, 1'b0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_fun = 4'd2; bus.req1_a = 32'hFFFF_FFFF; bus.req1_b = 32'd1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0);
      chk("bp_valid",  {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_result", bus.rsp_result,         32'h0000_F000);
      chk("bp_id",     {31'd0, bus.rsp_id},    32'd0);
    end
    bus.rsp_ready = 1'b1;
    cycle(1'b0, 1'b1);
    bus.req1_valid = 1'b0;
    chk("bp_next_valid",  {31'd0, bus.rsp_valid}, 32'd1);
    chk("bp_next_result", bus.rsp_result,         32'd1);
    chk("bp_next_id",     {31'd0, bus.rsp_id},    32'd1);
    cycle(1'b0, 1'b0);

    // Reset with a held, undrained result.
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_fun = 4'd0; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
    cycle(1'b1, 1'b0);
    chk("pre_rst_valid", {31'd0, bus.rsp_valid}, 32'd1);
    RST_N = 1'b0;
    bus.req1_valid = 1'b1;
    cycle(1'b0, 1'b0);
    sb.delete();
    chk("mid_rst_valid",  {31'd0, bus.rsp_valid}, 32'd0);
    chk("mid_rst_result", bus.rsp_result,         32'd0);
    RST_N = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req0_fun = 4'd6; bus.req0_a = 32'h0000_0F00; bus.req0_b = 32'h0000_00F0;
    bus.req1_fun = 4'd5; bus.req1_a = 32'h8000_0000; bus.req1_b = 32'd31;
    cycle(1'b1, 1'b0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    cycle(1'b0, 1'b0);
    chk("sb_empty", sb.size(), 32'd0);

    // Fixed priority: req0 wins every tie.
    bus_fp.rsp_ready = 1'b1;
    bus_fp.req0_valid = 1'b1; bus_fp.req0_fun = 4'd9; bus_fp.req0_a = 32'h0000_1234; bus_fp.req0_b = 32'd0;
    bus_fp.req1_valid = 1'b1; bus_fp.req1_fun = 4'd0; bus_fp.req1_a = 32'd1;          bus_fp.req1_b = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("fp_req0_ready", {31'd0, bus_fp.req0_ready}, 32'd1);
      chk("fp_req1_ready", {31'd0, bus_fp.req1_ready}, 32'd0);
      @(posedge CLK);
      #1;
      chk("fp_id",     {31'd0, bus_fp.rsp_id}, 32'd0);
      chk("fp_result", bus_fp.rsp_result,      32'h0000_1234);
    end
    bus_fp.req0_valid = 1'b0;
    bus_fp.req1_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
